// File: rtl/cpu_stage_sequencer.sv
// Multi-cycle control sequencer for the RV32I core: IF -> ID -> EX -> MEM -> WB.
// Owns the PC, memory handshakes, register-file write gating and cycle/instret counters.
module cpu_stage_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_8000,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        ir_we,
    output logic        dec_en,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_halt,
    input  logic        dec_reg_we,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic [2:0]  stage,
    output logic        halted,
    output logic [1:0]  err,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret
);

    localparam int unsigned WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } stage_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ALIGN   = 2'b10;

    stage_t         state, state_n;
    logic [31:0]    pc_n, cycle_n, instret_n, pc_nxt;
    logic [1:0]     err_n;
    logic [WW-1:0]  wait_cnt, wait_n;
    logic           imem_req_c, ir_we_c, dec_en_c, dmem_req_c, dmem_we_c, rf_we_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IF;
            pc        <= RESET_PC;
            err       <= ERR_NONE;
            cycle_cnt <= '0;
            instret   <= '0;
            wait_cnt  <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            err       <= err_n;
            cycle_cnt <= cycle_n;
            instret   <= instret_n;
            wait_cnt  <= wait_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        err_n      = err;
        instret_n  = instret;
        wait_n     = wait_cnt;
        cycle_n    = (state == ST_HALT) ? cycle_cnt : cycle_cnt + 32'd1;
        pc_nxt     = br_taken ? br_target : pc + 32'd4;
        imem_req_c = 1'b0;
        ir_we_c    = 1'b0;
        dec_en_c   = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        rf_we_c    = 1'b0;

        case (state)
            ST_IF: begin
                imem_req_c = 1'b1;
                // ack in the expiring cycle still wins over the timeout
                if (imem_ack) begin
                    ir_we_c = 1'b1;
                    state_n = ST_ID;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_n = ST_HALT;
                    err_n   = ERR_TIMEOUT;
                end else begin
                    wait_n = wait_cnt + WW'(1);
                end
            end
            ST_ID: begin
                dec_en_c = 1'b1;
                state_n  = ST_EX;
            end
            ST_EX: begin
                if (is_halt) begin
                    state_n = ST_HALT;
                end else if (is_load || is_store) begin
                    state_n = ST_MEM;
                    wait_n  = '0;
                end else begin
                    state_n = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = is_store;
                if (dmem_ack) begin
                    state_n = ST_WB;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_n = ST_HALT;
                    err_n   = ERR_TIMEOUT;
                end else begin
                    wait_n = wait_cnt + WW'(1);
                end
            end
            ST_WB: begin
                rf_we_c   = dec_reg_we;
                instret_n = instret + 32'd1;
                wait_n    = '0;
                // a misaligned next PC retires the instruction but keeps the old PC
                if (pc_nxt[1:0] != 2'b00) begin
                    state_n = ST_HALT;
                    err_n   = ERR_ALIGN;
                end else begin
                    pc_n    = pc_nxt;
                    state_n = ST_IF;
                end
            end
            default: begin
                state_n = ST_HALT;
            end
        endcase
    end

    assign imem_req = rst & imem_req_c;
    assign ir_we    = rst & ir_we_c;
    assign dec_en   = rst & dec_en_c;
    assign dmem_req = rst & dmem_req_c;
    assign dmem_we  = rst & dmem_we_c;
    assign rf_we    = rst & rf_we_c;
    assign stage    = state;
    assign halted   = (state == ST_HALT);

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Directed self-checking bench for cpu_stage_sequencer with hand-computed expectations.
module tb_cpu_stage_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack, ir_we, dec_en;
    logic        is_load, is_store, is_halt, dec_reg_we;
    logic        dmem_req, dmem_we, dmem_ack;
    logic        br_taken;
    logic [31:0] br_target;
    logic        rf_we;
    logic [31:0] pc;
    logic [2:0]  stage;
    logic        halted;
    logic [1:0]  err;
    logic [31:0] cycle_cnt, instret;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    cpu_stage_sequencer #(
        .RESET_PC    (32'h0000_8000),
        .MEM_TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .ir_we      (ir_we),
        .dec_en     (dec_en),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_halt    (is_halt),
        .dec_reg_we (dec_reg_we),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .rf_we      (rf_we),
        .pc         (pc),
        .stage      (stage),
        .halted     (halted),
        .err        (err),
        .cycle_cnt  (cycle_cnt),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        is_load = 1'b0; is_store = 1'b0; is_halt = 1'b0; dec_reg_we = 1'b0;
        br_taken = 1'b0; br_target = '0;

        // Reset state
        tick(); tick();
        chk("rst_stage", 32'(stage), 32'd0);
        chk("rst_pc", pc, 32'h8000);
        chk("rst_cyc", cycle_cnt, 32'd0);
        chk("rst_iret", instret, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_imreq_forced", 32'(imem_req), 32'd0);

        // ADD with immediate fetch ack
        rst = 1'b1; imem_ack = 1'b1; dec_reg_we = 1'b1; settle();
        chk("add_if_req", 32'(imem_req), 32'd1);
        chk("add_if_irwe", 32'(ir_we), 32'd1);
        tick(); imem_ack = 1'b0; settle();
        chk("add_id_stage", 32'(stage), 32'd1);
        chk("add_id_decen", 32'(dec_en), 32'd1);
        chk("add_id_imreq", 32'(imem_req), 32'd0);
        tick();
        chk("add_ex_stage", 32'(stage), 32'd2);
        chk("add_ex_decen", 32'(dec_en), 32'd0);
        tick();
        chk("add_wb_stage", 32'(stage), 32'd4);
        chk("add_wb_rfwe", 32'(rf_we), 32'd1);
        chk("add_wb_pc", pc, 32'h8000);
        tick();
        chk("add_done_stage", 32'(stage), 32'd0);
        chk("add_done_pc", pc, 32'h8004);
        chk("add_done_iret", instret, 32'd1);
        chk("add_done_cyc", cycle_cnt, 32'd4);
        chk("add_done_rfwe", 32'(rf_we), 32'd0);

        // LW with dmem_ack three cycles late
        imem_ack = 1'b1; settle();
        tick(); imem_ack = 1'b0; settle();
        tick(); is_load = 1'b1; settle();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("lw_mem_stage", 32'(stage), 32'd3);
            chk("lw_mem_req", 32'(dmem_req), 32'd1);
            chk("lw_mem_we", 32'(dmem_we), 32'd0);
            tick();
        end
        dmem_ack = 1'b1; settle();
        chk("lw_mem_req4", 32'(dmem_req), 32'd1);
        tick(); dmem_ack = 1'b0; is_load = 1'b0; settle();
        chk("lw_wb_stage", 32'(stage), 32'd4);
        chk("lw_wb_rfwe", 32'(rf_we), 32'd1);
        tick();
        chk("lw_done_pc", pc, 32'h8008);
        chk("lw_done_iret", instret, 32'd2);
        chk("lw_done_cyc", cycle_cnt, 32'd12);

        // SW with immediate dmem_ack
        imem_ack = 1'b1; settle();
        tick(); imem_ack = 1'b0; settle();
        tick(); is_store = 1'b1; dec_reg_we = 1'b0; settle();
        tick(); dmem_ack = 1'b1; settle();
        chk("sw_mem_req", 32'(dmem_req), 32'd1);
        chk("sw_mem_we", 32'(dmem_we), 32'd1);
        tick(); dmem_ack = 1'b0; is_store = 1'b0; settle();
        chk("sw_wb_we", 32'(dmem_we), 32'd0);
        chk("sw_wb_rfwe", 32'(rf_we), 32'd0);
        tick();
        chk("sw_done_pc", pc, 32'h800C);
        chk("sw_done_iret", instret, 32'd3);
        chk("sw_done_cyc", cycle_cnt, 32'd17);

        // Reset asserted for 3 cycles while a load is waiting in MEM
        imem_ack = 1'b1; settle();
        tick(); imem_ack = 1'b0; settle();
        tick(); is_load = 1'b1; settle();
        tick();
        chk("rmem_req_before", 32'(dmem_req), 32'd1);
        rst = 1'b0; settle();
        chk("rmem_req_forced", 32'(dmem_req), 32'd0);
        tick(); tick(); tick();
        chk("rmem_stage", 32'(stage), 32'd0);
        chk("rmem_pc", pc, 32'h8000);
        chk("rmem_cyc", cycle_cnt, 32'd0);
        chk("rmem_iret", instret, 32'd0);
        rst = 1'b1; is_load = 1'b0; settle();
        chk("rmem_dreq_after", 32'(dmem_req), 32'd0);
        chk("rmem_imreq_after", 32'(imem_req), 32'd1);

        // Branches: 0x8100, 0xFFFFFFFC, wrap to 0, then misaligned target
        dec_reg_we = 1'b1;
        for (int k = 0; k < 4; k++) begin
            imem_ack = 1'b1; settle();
            tick(); imem_ack = 1'b0; settle();
            tick(); tick();
            case (k)
                0: begin br_taken = 1'b1; br_target = 32'h0000_8100; end
                1: begin br_taken = 1'b1; br_target = 32'hFFFF_FFFC; end
                2: begin br_taken = 1'b0; br_target = 32'h0000_1234; end
                default: begin br_taken = 1'b1; br_target = 32'h0000_8102; end
            endcase
            settle();
            chk("br_wb_rfwe", 32'(rf_we), 32'd1);
            tick();
            case (k)
                0: chk("br_pc_8100", pc, 32'h0000_8100);
                1: chk("br_pc_fffc", pc, 32'hFFFF_FFFC);
                2: chk("br_pc_wrap", pc, 32'h0000_0000);
                default: chk("br_mis_pc", pc, 32'h0000_0000);
            endcase
            chk("br_iret", instret, 32'(k + 1));
        end
        br_taken = 1'b0;
        chk("br_mis_stage", 32'(stage), 32'd5);
        chk("br_mis_halted", 32'(halted), 32'd1);
        chk("br_mis_err", 32'(err), 32'd2);
        chk("br_mis_cyc", cycle_cnt, 32'd16);
        tick(); tick(); tick();
        chk("br_halt_cyc", cycle_cnt, 32'd16);
        chk("br_halt_imreq", 32'(imem_req), 32'd0);

        // Fetch timeout: no imem_ack for 16 cycles
        rst = 1'b0; tick(); rst = 1'b1; dec_reg_we = 1'b0; settle();
        for (int i = 0; i < 16; i++) begin
            chk("ito_stage", 32'(stage), 32'd0);
            chk("ito_req", 32'(imem_req), 32'd1);
            tick();
        end
        chk("ito_halt_stage", 32'(stage), 32'd5);
        chk("ito_err", 32'(err), 32'd1);
        chk("ito_req_drop", 32'(imem_req), 32'd0);
        chk("ito_cyc", cycle_cnt, 32'd16);

        // Ack on the 16th waiting cycle wins
        rst = 1'b0; tick(); rst = 1'b1; settle();
        for (int i = 0; i < 15; i++) tick();
        chk("ilast_stage", 32'(stage), 32'd0);
        imem_ack = 1'b1; settle();
        chk("ilast_irwe", 32'(ir_we), 32'd1);
        tick(); imem_ack = 1'b0; settle();
        chk("ilast_id", 32'(stage), 32'd1);
        chk("ilast_err", 32'(err), 32'd0);

        // Data timeout: store never acked
        tick(); is_store = 1'b1; settle();
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("dto_stage", 32'(stage), 32'd3);
            chk("dto_we", 32'(dmem_we), 32'd1);
            tick();
        end
        is_store = 1'b0; settle();
        chk("dto_halt", 32'(stage), 32'd5);
        chk("dto_err", 32'(err), 32'd1);
        chk("dto_req_drop", 32'(dmem_req), 32'd0);
        chk("dto_iret", instret, 32'd0);

        // One ADD, then a halt instruction; counters freeze
        rst = 1'b0; tick(); rst = 1'b1; dec_reg_we = 1'b1; imem_ack = 1'b1; settle();
        tick(); imem_ack = 1'b0; settle();
        tick(); tick(); tick();
        chk("hlt_add_iret", instret, 32'd1);
        imem_ack = 1'b1; settle();
        tick(); imem_ack = 1'b0; settle();
        tick(); is_halt = 1'b1; settle();
        tick(); is_halt = 1'b0; settle();
        chk("hlt_stage", 32'(stage), 32'd5);
        chk("hlt_cyc", cycle_cnt, 32'd7);
        chk("hlt_iret", instret, 32'd1);
        chk("hlt_err", 32'(err), 32'd0);
        for (int i = 0; i < 50; i++) tick();
        chk("hlt_cyc_frozen", cycle_cnt, 32'd7);
        chk("hlt_iret_frozen", instret, 32'd1);
        chk("hlt_stage_stay", 32'(stage), 32'd5);
        chk("hlt_rfwe", 32'(rf_we), 32'd0);
        rst = 1'b0; tick(); rst = 1'b1; settle();
        chk("hlt_restart_stage", 32'(stage), 32'd0);
        chk("hlt_restart_pc", pc, 32'h8000);
        chk("hlt_restart_req", 32'(imem_req), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
